// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the two-input round-robin arbiter / mux front end.
// Optional grant counters are enabled with ARB_GRANT_CNT_EN.
package rr_arb_pkg;

    localparam logic SEL_IN0    = 1'b0;
    localparam logic SEL_IN1    = 1'b1;

    localparam int   DEF_DATA_W = 8;
    localparam int   DEF_CNT_W  = 16;

    typedef struct packed {
        logic                  valid;
        logic [DEF_DATA_W-1:0] data;
    } chan_t;

endpackage

// File: rtl/rr_arb_mux_2_1_if.sv
// Valid/ready bundle between two producers, the arbiter and the downstream consumer.
// The master modport is the environment side; the slave modport is the arbiter.
interface rr_arb_mux_2_1_if #(
    parameter int DATA_W = rr_arb_pkg::DEF_DATA_W
);
    logic              in0_valid;
    logic [DATA_W-1:0] in0_data;
    logic              in0_ready;
    logic              in1_valid;
    logic [DATA_W-1:0] in1_data;
    logic              in1_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_sel;
    logic              out_ready;

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_arb_mux_2_1_sat_counter.sv
// Saturating up-counter: async reset, synchronous clear, stops at all-ones.
module sat_counter #(
    parameter int CNT_W = rr_arb_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/rr_arb_mux_2_1.sv
// Two-input round-robin arbiter with a registered, handshaken output word and mux select.
// Define ARB_GRANT_CNT_EN to add saturating per-channel grant counters.
module rr_arb_mux_2_1
    import rr_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    rr_arb_mux_2_1_if.slave  bus
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_sel_q,   out_sel_d;
    logic              last_grant_q, last_grant_d;

    logic              load_en_s;
    logic              grant_vld_s;
    logic              grant_s;
    logic              rdy0_s;
    logic              rdy1_s;

    // Readys are suppressed while reset is held so nothing is accepted then.
    assign load_en_s = !rst && (!out_valid_q || bus.out_ready);

    // Arbitration: single requester wins outright, a tie goes against the last winner.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = SEL_IN0;
        if (load_en_s) begin
            case ({bus.in1_valid, bus.in0_valid})
                2'b01: begin
                    grant_vld_s = 1'b1;
                    grant_s     = SEL_IN0;
                end
                2'b10: begin
                    grant_vld_s = 1'b1;
                    grant_s     = SEL_IN1;
                end
                2'b11: begin
                    grant_vld_s = 1'b1;
                    grant_s     = ~last_grant_q;
                end
                default: begin
                    grant_vld_s = 1'b0;
                    grant_s     = SEL_IN0;
                end
            endcase
        end else begin
            grant_vld_s = 1'b0;
            grant_s     = SEL_IN0;
        end
    end

    assign rdy0_s = grant_vld_s && (grant_s == SEL_IN0);
    assign rdy1_s = grant_vld_s && (grant_s == SEL_IN1);

    // Output stage next state: load on grant, drain when accepted with nothing new.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        last_grant_d = last_grant_q;
        if (grant_vld_s) begin
            out_valid_d  = 1'b1;
            out_data_d   = (grant_s == SEL_IN1) ? bus.in1_data : bus.in0_data;
            out_sel_d    = grant_s;
            last_grant_d = grant_s;
        end else if (bus.out_ready) begin
            out_valid_d  = 1'b0;
        end else begin
            out_valid_d  = out_valid_q;
        end
    end

    // Output and round-robin registers; last_grant resets to 1 so the first tie goes to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= {DATA_W{1'b0}};
            out_sel_q    <= SEL_IN0;
            last_grant_q <= SEL_IN1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.in0_ready = rdy0_s;
    assign bus.in1_ready = rdy1_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

`ifdef ARB_GRANT_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_cnt0 (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (rdy0_s),
        .cnt_o (grant_cnt0)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt1 (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (rdy1_s),
        .cnt_o (grant_cnt1)
    );
`endif
endmodule
